// File: rtl/ressource_grid_subscriber_mc_if.sv
// AXI-stream bundle used for both the multi-channel IQ input and the serialised output.
interface ressource_grid_subscriber_mc_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned USER_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic [USER_W-1:0] tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/ressource_grid_subscriber_mc.sv
// Multi-channel resource-grid subscriber: admits whole masked OFDM symbols into a FIFO,
// prefixes each with its timing tag and serialises the channels onto one AXI stream.
module ressource_grid_subscriber_mc #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned IQ_WIDTH     = 32,
    parameter int unsigned MAX_SC       = 240,
    parameter int unsigned DATA_DEPTH   = 1024,
    parameter int unsigned HDR_DEPTH    = 8,
    parameter int unsigned USER_WIDTH   = 20
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    ressource_grid_subscriber_mc_if.slave        s_axis_iq,
    ressource_grid_subscriber_mc_if.master       m_axis,
    input  logic                                 enable_i,
    input  logic [13:0]                          sym_mask_i,
    input  logic [7:0]                           int_every_i,
    output logic [15:0]                          dropped_o,
    output logic [15:0]                          truncated_o,
    output logic                                 int_o
);
    localparam int unsigned EntryW = NUM_CHANNELS * IQ_WIDTH + 1;
    localparam int unsigned DAw    = $clog2(DATA_DEPTH);
    localparam int unsigned HAw    = $clog2(HDR_DEPTH);
    localparam int unsigned ScW    = $clog2(MAX_SC + 1);
    localparam int unsigned ChW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [DAw:0]    DataDepthW = DATA_DEPTH[DAw:0];
    localparam logic [DAw:0]    MaxScD     = MAX_SC[DAw:0];
    localparam logic [HAw:0]    HdrDepthW  = HDR_DEPTH[HAw:0];
    localparam logic [ScW-1:0]  MaxScC     = MAX_SC[ScW-1:0];
    localparam logic [ChW-1:0]  LastCh     = ChW'(NUM_CHANNELS - 1);

    localparam logic [1:0] InAlign   = 2'd0;
    localparam logic [1:0] InIdle    = 2'd1;
    localparam logic [1:0] InAccept  = 2'd2;
    localparam logic [1:0] InDiscard = 2'd3;

    localparam logic [1:0] OutIdle = 2'd0;
    localparam logic [1:0] OutHdr  = 2'd1;
    localparam logic [1:0] OutData = 2'd2;

    logic [EntryW-1:0]     data_mem [DATA_DEPTH];
    logic [USER_WIDTH-1:0] hdr_mem  [HDR_DEPTH];

    logic [1:0]     in_state_q, in_state_d, out_state_q, out_state_d;
    logic [ScW-1:0] sc_cnt_q, sc_cnt_d, sc_next;
    logic [ChW-1:0] ch_q, ch_d;
    logic [DAw:0]   d_wptr_q, d_rptr_q, d_count, d_free;
    logic [HAw:0]   h_wptr_q, h_rptr_q, h_count;
    logic [15:0]    dropped_q, truncated_q;
    logic [7:0]     deliv_q, deliv_next;
    logic           int_q;

    logic d_push, d_push_last, h_push, d_pop, h_pop;
    logic drop_inc, trunc_inc, deliver, fire;
    logic want, space_ok, last_ch;
    logic [15:0] mask_ext;
    logic [EntryW-1:0] d_head;
    logic [IQ_WIDTH-1:0] m_tdata;
    logic m_tvalid, m_tuser, m_tlast;

    // Free space uses registered pointers only, so a same-cycle pop never helps admission.
    assign d_count  = d_wptr_q - d_rptr_q;
    assign d_free   = DataDepthW - d_count;
    assign h_count  = h_wptr_q - h_rptr_q;
    assign space_ok = (d_free >= MaxScD) && (h_count != HdrDepthW);
    assign mask_ext = {2'b00, sym_mask_i};
    assign want     = enable_i && mask_ext[s_axis_iq.tuser[4:1]];
    assign sc_next  = sc_cnt_q + 1'b1;
    assign d_head   = data_mem[d_rptr_q[DAw-1:0]];

    always_comb begin
        in_state_d  = in_state_q;
        sc_cnt_d    = sc_cnt_q;
        d_push      = 1'b0;
        d_push_last = 1'b0;
        h_push      = 1'b0;
        drop_inc    = 1'b0;
        trunc_inc   = 1'b0;
        case (in_state_q)
            InAlign: if (s_axis_iq.tvalid && s_axis_iq.tlast) in_state_d = InIdle;
            InIdle: if (s_axis_iq.tvalid) begin
                if (want && space_ok) begin
                    h_push      = 1'b1;
                    d_push      = 1'b1;
                    d_push_last = s_axis_iq.tlast || (MaxScC == ScW'(1));
                    sc_cnt_d    = ScW'(1);
                    if (s_axis_iq.tlast) begin
                        in_state_d = InIdle;
                    end else if (MaxScC == ScW'(1)) begin
                        trunc_inc  = 1'b1;
                        in_state_d = InDiscard;
                    end else begin
                        in_state_d = InAccept;
                    end
                end else begin
                    // Only symbols that were wanted but did not fit count as drops.
                    drop_inc = want;
                    if (!s_axis_iq.tlast) in_state_d = InDiscard;
                end
            end
            InAccept: if (s_axis_iq.tvalid) begin
                d_push      = 1'b1;
                sc_cnt_d    = sc_next;
                d_push_last = s_axis_iq.tlast || (sc_next == MaxScC);
                if (s_axis_iq.tlast) begin
                    in_state_d = InIdle;
                end else if (sc_next == MaxScC) begin
                    trunc_inc  = 1'b1;
                    in_state_d = InDiscard;
                end
            end
            InDiscard: if (s_axis_iq.tvalid && s_axis_iq.tlast) in_state_d = InIdle;
            default: in_state_d = InAlign;
        endcase
    end

    always_comb begin
        out_state_d = out_state_q;
        ch_d        = ch_q;
        d_pop       = 1'b0;
        h_pop       = 1'b0;
        deliver     = 1'b0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tuser     = 1'b0;
        m_tlast     = 1'b0;
        last_ch     = (ch_q == LastCh);
        case (out_state_q)
            OutIdle: if (h_count != '0) out_state_d = OutHdr;
            OutHdr: begin
                m_tvalid                   = 1'b1;
                m_tuser                    = 1'b1;
                m_tdata[USER_WIDTH-1:0]    = hdr_mem[h_rptr_q[HAw-1:0]];
                if (m_axis.tready) begin
                    h_pop       = 1'b1;
                    out_state_d = OutData;
                end
            end
            OutData: if (d_count != '0) begin
                m_tvalid = 1'b1;
                m_tdata  = d_head[ch_q*IQ_WIDTH +: IQ_WIDTH];
                m_tlast  = last_ch && d_head[EntryW-1];
                if (m_axis.tready) begin
                    if (last_ch) begin
                        d_pop = 1'b1;
                        ch_d  = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                    if (m_tlast) begin
                        deliver     = 1'b1;
                        out_state_d = OutIdle;
                    end
                end
            end
            default: out_state_d = OutIdle;
        endcase
    end

    // Counter is compared with >= so lowering int_every_i fires on the next delivery.
    assign deliv_next = (deliv_q == 8'hFF) ? deliv_q : deliv_q + 8'd1;
    assign fire       = deliver && (int_every_i != 8'd0) && (deliv_next >= int_every_i);

    always_ff @(posedge clk_i) begin
        if (d_push) data_mem[d_wptr_q[DAw-1:0]] <= {d_push_last, s_axis_iq.tdata};
        if (h_push) hdr_mem[h_wptr_q[HAw-1:0]] <= s_axis_iq.tuser;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_state_q  <= InAlign;
            out_state_q <= OutIdle;
            sc_cnt_q    <= '0;
            ch_q        <= '0;
            d_wptr_q    <= '0;
            d_rptr_q    <= '0;
            h_wptr_q    <= '0;
            h_rptr_q    <= '0;
            dropped_q   <= '0;
            truncated_q <= '0;
            deliv_q     <= '0;
            int_q       <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            sc_cnt_q    <= sc_cnt_d;
            ch_q        <= ch_d;
            if (d_push) d_wptr_q <= d_wptr_q + 1'b1;
            if (d_pop)  d_rptr_q <= d_rptr_q + 1'b1;
            if (h_push) h_wptr_q <= h_wptr_q + 1'b1;
            if (h_pop)  h_rptr_q <= h_rptr_q + 1'b1;
            if (drop_inc && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
            if (trunc_inc && truncated_q != 16'hFFFF) truncated_q <= truncated_q + 16'd1;
            if (deliver) deliv_q <= fire ? 8'd0 : deliv_next;
            int_q <= fire;
        end
    end

    assign s_axis_iq.tready = 1'b1;
    assign m_axis.tdata     = m_tdata;
    assign m_axis.tvalid    = m_tvalid;
    assign m_axis.tuser     = m_tuser;
    assign m_axis.tlast     = m_tlast;
    assign dropped_o        = dropped_q;
    assign truncated_o      = truncated_q;
    assign int_o            = int_q;
endmodule

// File: tb/tb_ressource_grid_subscriber_mc.sv
// Bench for the multi-channel grid subscriber: symbol-level reference model feeding an
// expected-beat queue that an output monitor consumes on every handshake.
module tb_ressource_grid_subscriber_mc;
    localparam int unsigned NC  = 2;
    localparam int unsigned IQW = 32;
    localparam int unsigned MSC = 240;
    localparam int unsigned DD  = 1024;
    localparam int unsigned HD  = 8;
    localparam int unsigned UW  = 20;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable;
    logic [13:0] mask;
    logic [7:0]  int_every;
    logic [15:0] dropped, truncated;
    logic        irq;

    always #5 clk = ~clk;

    ressource_grid_subscriber_mc_if #(.DATA_W(NC*IQW), .USER_W(UW)) s_if ();
    ressource_grid_subscriber_mc_if #(.DATA_W(IQW), .USER_W(1)) m_if ();

    ressource_grid_subscriber_mc #(
        .NUM_CHANNELS(NC), .IQ_WIDTH(IQW), .MAX_SC(MSC),
        .DATA_DEPTH(DD), .HDR_DEPTH(HD), .USER_WIDTH(UW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .s_axis_iq(s_if.slave), .m_axis(m_if.master),
        .enable_i(enable), .sym_mask_i(mask), .int_every_i(int_every),
        .dropped_o(dropped), .truncated_o(truncated), .int_o(irq)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    typedef struct {
        logic [19:0] tuser;
        int          beats;
        bit          en;
        logic [13:0] mask;
        bit          exp_admit;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, delivered = 0, int_pulses = 0, hdr_cyc = -1, beat_cyc = 0;
    int mode = 0;  // tready: 0 low, 1 high, 2 random
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_user, prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0: m_if.tready = 1'b0;
                1: m_if.tready = 1'b1;
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_stable", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata},
                          {1'b1, prev_user, prev_last, prev_data});
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL out_beat: got %0h user %0b last %0b expected no beat",
                                 m_if.tdata, m_if.tuser, m_if.tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, e);
                    end
                    if (m_if.tlast) delivered++;
                end
                if (m_if.tvalid && m_if.tuser && hdr_cyc < 0) hdr_cyc = cyc;
                if (irq) int_pulses++;
                prev_stall = m_if.tvalid && !m_if.tready;
                prev_data  = m_if.tdata;
                prev_user  = m_if.tuser;
                prev_last  = m_if.tlast;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b0;
            s_if.tlast  = 1'b0;
        end
    endtask

    // Drives beats [first, first+count) of a symbol of length beats; records expectations.
    task automatic send_part(input logic [19:0] tu, input int beats, input int first,
                             input int count, input bit admit);
        for (int b = first; b < first + count; b++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1;
            s_if.tuser  = tu;
            s_if.tlast  = (b == beats - 1);
            for (int c = 0; c < NC; c++) s_if.tdata[c*IQW +: IQW] = $urandom;
            if (admit) begin
                if (b == 0) begin
                    exp_q.push_back('{data: 32'(tu), user: 1'b1, last: 1'b0});
                    beat_cyc = cyc;
                end
                if (b < MSC)
                    for (int c = 0; c < NC; c++)
                        exp_q.push_back('{data: s_if.tdata[c*IQW +: IQW], user: 1'b0,
                                          last: (c == NC - 1) && (b == beats - 1 || b == MSC - 1)});
            end
        end
    endtask

    task automatic send_sym(input logic [19:0] tu, input int beats, input bit admit);
        send_part(tu, beats, 0, beats, admit);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tvalid"}, m_if.tvalid, 0);
        check({tag, "_tlast"}, m_if.tlast, 0);
        check({tag, "_tuser"}, m_if.tuser, 0);
        check({tag, "_tdata"}, m_if.tdata, 0);
        check({tag, "_int"}, irq, 0);
        check({tag, "_dropped"}, dropped, 0);
        check({tag, "_truncated"}, truncated, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_i     = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset_i    = 1'b0;
        delivered  = 0;
        int_pulses = 0;
    endtask

    task automatic align();
        send_sym(20'h0, 1, 1'b0);
        idle(2);
    endtask

    initial begin
        int exp_drop, stored, hdrs, n_admit;
        bit admit;
        logic [3:0] sym;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        s_if.tdata  = '0;
        enable      = 1'b1;
        mask        = 14'h3FFF;
        int_every   = 8'd0;
        repeat (3) @(posedge clk);

        // Single 4-beat symbol, header latency and interrupt every delivery.
        mode = 1;
        int_every = 8'd1;
        do_reset();
        align();
        hdr_cyc = -1;
        send_sym(20'h00A35, 4, 1'b1);
        idle(1);
        wait_drain("drain_single", 200);
        check("hdr_latency", (hdr_cyc >= 0) && (hdr_cyc - beat_cyc <= 2), 1);
        check("single_delivered", delivered, 1);
        check("single_int", int_pulses, 1);

        // Table of mask/enable admission vectors.
        for (int s = 0; s < 14; s++)
            vecs.push_back('{tuser: {10'(s * 37), 5'(s), 4'(s), 1'b0}, beats: 12, en: 1'b1,
                             mask: 14'h0001, exp_admit: (s == 0)});
        vecs.push_back('{tuser: 20'h00106, beats: 5, en: 1'b0, mask: 14'h3FFF, exp_admit: 1'b0});
        vecs.push_back('{tuser: 20'h00106, beats: 5, en: 1'b1, mask: 14'h3FFF, exp_admit: 1'b1});
        vecs.push_back('{tuser: 20'h0021A, beats: 1, en: 1'b1, mask: 14'h2000, exp_admit: 1'b1});
        vecs.push_back('{tuser: 20'h00318, beats: 3, en: 1'b1, mask: 14'h2000, exp_admit: 1'b0});
        int_every = 8'd0;
        do_reset();
        align();
        n_admit = 0;
        foreach (vecs[i]) begin
            enable = vecs[i].en;
            mask   = vecs[i].mask;
            send_sym(vecs[i].tuser, vecs[i].beats, vecs[i].exp_admit);
            idle(1);
            if (vecs[i].exp_admit) n_admit++;
        end
        enable = 1'b1;
        mask   = 14'h3FFF;
        wait_drain("drain_table", 1000);
        check("table_delivered", delivered, n_admit);
        check("table_dropped", dropped, 0);

        // Output fully stalled: admission limited by data FIFO space.
        mode = 0;
        do_reset();
        align();
        stored = 0;
        hdrs = 0;
        exp_drop = 0;
        for (int k = 0; k < 6; k++) begin
            admit = ((DD - stored) >= MSC) && (hdrs < HD);
            if (admit) begin
                stored += MSC;
                hdrs++;
            end else begin
                exp_drop++;
            end
            send_sym({15'(k), 4'(k), 1'b0}, MSC, admit);
            check("stall_dropped_step", dropped, exp_drop);
        end
        idle(2);
        mode = 1;
        wait_drain("drain_stalled", 4000);
        check("stall_delivered", delivered, 4);
        check("stall_dropped", dropped, 2);

        // Oversized symbol truncated at MAX_SC, following symbol intact.
        do_reset();
        align();
        send_sym(20'h00024, 300, 1'b1);
        idle(1);
        send_sym(20'h0004A, 10, 1'b1);
        idle(1);
        wait_drain("drain_trunc", 2000);
        check("trunc_count", truncated, 1);
        check("trunc_dropped", dropped, 0);
        check("trunc_delivered", delivered, 2);

        // Random tready with random symbols and an interrupt every 5 deliveries.
        mode = 2;
        int_every = 8'd5;
        do_reset();
        align();
        for (int k = 0; k < 20; k++) begin
            sym = 4'($urandom_range(0, 13));
            send_sym({15'($urandom), sym, 1'($urandom)}, $urandom_range(1, 12), 1'b1);
            idle(60);
        end
        wait_drain("drain_random", 5000);
        check("rand_delivered", delivered, 20);
        check("rand_int", int_pulses, 4);
        check("rand_dropped", dropped, 0);

        // Reset in the middle of an admitted symbol.
        mode = 1;
        int_every = 8'd0;
        do_reset();
        align();
        send_part(20'h00008, 10, 0, 5, 1'b1);
        @(posedge clk); #1;
        reset_i     = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        reset_i   = 1'b0;
        delivered = 0;
        send_part(20'h00008, 10, 5, 5, 1'b0);
        idle(2);
        send_sym(20'h0000C, 6, 1'b1);
        idle(1);
        wait_drain("drain_after_reset", 500);
        check("after_reset_delivered", delivered, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ressource_grid_subscriber_mc.md
Name: ressource_grid_subscriber_mc

Overview:
- Multi-antenna successor of the single-channel grid subscriber.
- Takes NUM_CHANNELS parallel resource-grid streams from FFT_demod and filters whole OFDM symbols by a symbol mask.
- Admits symbols only when they fit completely, so there are never partial symbols. Prefixes each admitted symbol with a header word carrying its timing tag.
- Serialises channels into one AXI stream toward the AXI ring writer, and raises a CPU interrupt every int_every_i delivered symbols.

Parameters:
- NUM_CHANNELS, 2, antenna channels per input beat (1..8).
- IQ_WIDTH, 32, bits per IQ sample; must be >= USER_WIDTH.
- MAX_SC, 240, maximum input beats (subcarriers) per symbol.
- DATA_DEPTH, 1024, data FIFO entries; must be >= MAX_SC. Power of two.
- HDR_DEPTH, 8, header FIFO entries. Power of two.
- USER_WIDTH, 20, tuser width: SFN(10) + subframe(5) + symbol(4) + flag(1). Symbol index = tuser[4:1].

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- s_axis_iq_tdata  in  NUM_CHANNELS*IQ_WIDTH  channel c at bits [c*IQ_WIDTH +: IQ_WIDTH].
- s_axis_iq_tvalid  in  1  beat valid. There is no tready: the source cannot be stalled.
- s_axis_iq_tuser  in  USER_WIDTH  timing tag; sampled on the first beat of each symbol.
- s_axis_iq_tlast  in  1  last subcarrier of the symbol.
- enable_i  in  1  admit new symbols.
- sym_mask_i  in  14  bit n = 1 forwards symbol n.
- int_every_i  in  8  delivered symbols per interrupt; 0 disables the interrupt.
- m_axis_tdata  out  IQ_WIDTH  header or sample.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- m_axis_tlast  out  1  final beat of a symbol.
- m_axis_tuser  out  1  high on header beats.
- dropped_o  out  16  saturating count of symbols dropped for lack of space.
- truncated_o  out  16  saturating count of symbols truncated at MAX_SC.
- int_o  out  1  one-cycle interrupt pulse.

Behaviour:
- Reset values: m_axis_tvalid, m_axis_tlast, m_axis_tuser, int_o, dropped_o, truncated_o = 0; m_axis_tdata = 0. Both FIFOs empty.
- Input FSM states: ALIGN, IDLE, ACCEPT, DISCARD.
  - After reset the FSM enters ALIGN. It discards beats until a tvalid & tlast beat, then moves to IDLE.
  - IDLE, on the first valid beat, evaluates admission. A symbol is admitted when all of the following hold:
    - enable_i = 1;
    - sym_mask_i[tuser[4:1]] = 1;
    - data FIFO free >= MAX_SC;
    - header FIFO not full.
  - Admitted (go to ACCEPT): push tuser to the header FIFO. Write the beat, with flag last = tlast, to the data FIFO.
  - Not admitted (go to DISCARD): if rejected only for lack of space, increment dropped_o. Masked or disabled symbols are not counted.
  - A single-beat symbol (tlast on its first beat) returns to IDLE immediately.
- ACCEPT:
  - Writes every valid beat and increments a beat counter.
  - On tlast, or when the counter reaches MAX_SC, the stored entry carries last = 1.
  - Reaching MAX_SC without tlast increments truncated_o and moves to DISCARD.
  - tlast returns the FSM to IDLE.
- DISCARD: drops beats until tlast, then goes to IDLE.
- enable_i and sym_mask_i are sampled only at the admission point. Changes mid-symbol affect the next symbol.
- Output FSM states: IDLE, HDR, DATA.
  - IDLE: when the header FIFO is non-empty, go to HDR.
  - HDR: present m_axis_tdata = zero-extended header with m_axis_tuser = 1. On handshake, pop the header and go to DATA.
  - DATA: serialise the data FIFO head, channel 0 first, one channel per handshake. Pop the entry after channel NUM_CHANNELS-1.
  - m_axis_tlast = 1 on the last channel of an entry flagged last. That handshake returns the FSM to IDLE.
- Output AXI rule: tdata, tuser and tlast are held stable while tvalid & !tready.
- DATA may stall (tvalid = 0) only if the data FIFO is empty. Beats of a symbol can still be arriving while it is being read out.
- Simultaneous FIFO write and read are legal in every state. Free space counts entries, and the read side's same-cycle pop does not increase free space for that cycle's admission check.
- Latency: the header appears on m_axis no later than 2 cycles after the first admitted input beat, provided the output FSM is idle.
- Interrupt:
  - A delivered-symbol counter increments on each tlast handshake.
  - When it equals int_every_i (int_every_i != 0), pulse int_o for one cycle and clear the counter.
  - A write to int_every_i does not clear the counter. A counter >= the new value fires on the next delivery.
- Counters saturate at 0xFFFF.
- Asserting reset_i mid-operation clears everything immediately. Symbols in flight are lost, and input re-aligns through ALIGN.

Test Plan:
- Single symbol, NUM_CHANNELS = 2, 4 beats, tuser = 0x00A35 (symbol 10), tready = 1, first symbol after the ALIGN tlast → output is header 0x00A35 with tuser = 1, then 8 samples in order ch0, ch1 per beat, tlast on the 8th; int_every_i = 1 gives int_o pulse = 1.
- sym_mask_i = 0x0001, symbols 0..13 of 12 beats each → only symbol 0 emitted (1 + 24 beats); dropped_o = 0.
- tready = 0 throughout, DATA_DEPTH = 1024, MAX_SC = 240, 240-beat symbols → 4 symbols admitted, 5th and later dropped; dropped_o increments per symbol. Releasing tready delivers exactly 4 complete symbols.
- 300-beat symbol with MAX_SC = 240 → 240 entries stored, tlast on the last channel of entry 240; truncated_o = 1; next symbol unaffected.
- Random tready at 50%, 20 back-to-back symbols → byte-exact order, one header per symbol, tdata held stable during stalls; int_every_i = 5 gives exactly 4 int_o pulses.
- reset_i pulsed mid-symbol → all outputs 0 the following cycle; the remaining beats of that symbol are discarded; the next full symbol is delivered intact.
